regfile_bypass_sb: RTL

- Parametrised register file for the pipelined datapath; the successor to the fixed 32x32, 2R/1W array.
- Adds synchronous reset that clears all registers, same-cycle write-to-read bypass, and an optional hardwired zero register.
- Adds a per-register busy scoreboard, set at decode and cleared at writeback, so the hazard unit can stall on pending producers.
- Sits between the decode stage (reads, issue) and the writeback stage (write).

---
 rtl/pipe_pkg.sv | 10 +
 rtl/regfile_bypass_sb_if.sv | 27 ++
 rtl/regfile_bypass_sb_read_port.sv | 37 +++
 rtl/regfile_bypass_sb.sv | 58 +++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: default widths, register-address and data-word types.
package pipe_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] data_t;

   localparam int unsigned ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_bypass_sb_if.sv
// Decode/writeback side bundle of the register file: read ports, write port, issue and busy.
interface regfile_bypass_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) ();
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              issue_en;
   logic [ADDR_W-1:0] issue_addr;
   logic              busy1;
   logic              busy2;

   modport master (
      output we, wa, wd, ra1, ra2, issue_en, issue_addr,
      input  rd1, rd2, busy1, busy2
   );

   modport slave (
      input  we, wa, wd, ra1, ra2, issue_en, issue_addr,
      output rd1, rd2, busy1, busy2
   );
endinterface

// File: rtl/regfile_bypass_sb_read_port.sv
// One combinational read port: array mux, same-cycle write forwarding and busy masking.
module rf_read_port
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] wa_i,
   input  logic [DATA_W-1:0] wd_i,
   input  logic [DATA_W-1:0] mem_i [NUM_REGS],
   input  logic [NUM_REGS-1:0] busy_i,
   output logic [DATA_W-1:0] rd_o,
   output logic              busy_o
);
   logic in_range;
   logic is_zero;
   logic hit;

   always_comb begin
      in_range = (int'(ra_i) < NUM_REGS);
      is_zero  = ZERO_REG && (ra_i == ADDR_W'(ZERO_ADDR));
      hit      = BYPASS && we_i && (wa_i == ra_i);
      rd_o     = '0;
      busy_o   = 1'b0;
      // Forwarded data also means the pending producer is done, so busy is masked.
      if (!rst_i && in_range && !is_zero) begin
         rd_o   = hit ? wd_i : mem_i[ra_i];
         busy_o = busy_i[ra_i] & ~hit;
      end
   end
endmodule

// File: rtl/regfile_bypass_sb.sv
// Parametrised 2R/1W register file with sync reset, write-to-read bypass and busy scoreboard.
module regfile_bypass_sb
   import pipe_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic clk,
   input logic rst,
   regfile_bypass_sb_if.slave rf
);
   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                wr_ok;
   logic                wr_in_range;
   logic                iss_ok;

   always_comb begin
      wr_in_range = rf.we && (int'(rf.wa) < NUM_REGS);
      wr_ok       = wr_in_range && !(ZERO_REG && rf.wa == ADDR_W'(ZERO_ADDR));
      iss_ok      = rf.issue_en && (int'(rf.issue_addr) < NUM_REGS)
                    && !(ZERO_REG && rf.issue_addr == ADDR_W'(ZERO_ADDR));
      busy_d = busy_q;
      if (wr_in_range) busy_d[rf.wa] = 1'b0;
      // Applied after the clear: a new producer supersedes the one completing.
      if (iss_ok) busy_d[rf.issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
         busy_q <= '0;
      end else begin
         if (wr_ok) mem_q[rf.wa] <= rf.wd;
         busy_q <= busy_d;
      end
   end

   rf_read_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rp1 (
      .rst_i(rst), .ra_i(rf.ra1), .we_i(rf.we), .wa_i(rf.wa), .wd_i(rf.wd),
      .mem_i(mem_q), .busy_i(busy_q), .rd_o(rf.rd1), .busy_o(rf.busy1)
   );

   rf_read_port #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
   ) u_rp2 (
      .rst_i(rst), .ra_i(rf.ra2), .we_i(rf.we), .wa_i(rf.wa), .wd_i(rf.wd),
      .mem_i(mem_q), .busy_i(busy_q), .rd_o(rf.rd2), .busy_o(rf.busy2)
   );
endmodule
